axi_line_read_arbiter: RTL

- Shares the single AXI read channel between two cache-line requesters, such as the I-side and D-side line-fill ports of the dumb cache.
- Accepts one line request at a time and issues one INCR burst per request, with the address aligned to the line.
- Routes the returned beats only to the requester that was granted.
- Grants round-robin when both requesters are pending; one transaction is outstanding at any time.

---
 rtl/axi_line_read_arbiter_if.sv | 52 +++++
 rtl/axi_line_read_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/axi_line_read_arbiter_if.sv
// Signal bundle between two line-fill requesters, the arbiter and the AXI read channel.
// "master" is the arbiter's view (it masters m_axi); "slave" is everything around it.
interface axi_line_read_arbiter_if;
    logic        s0_arvalid;
    logic        s0_arready;
    logic [63:0] s0_araddr;
    logic [63:0] s0_rdata;
    logic        s0_rvalid;
    logic        s0_rlast;
    logic        s0_rready;

    logic        s1_arvalid;
    logic        s1_arready;
    logic [63:0] s1_araddr;
    logic [63:0] s1_rdata;
    logic        s1_rvalid;
    logic        s1_rlast;
    logic        s1_rready;

    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [63:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic [63:0] m_axi_rdata;
    logic        m_axi_rvalid;
    logic        m_axi_rlast;
    logic        m_axi_rready;

    // Every channel is valid/ready: a transfer happens on a rising edge where both are high,
    // and the sender holds payload stable while valid is high and ready is low.
    modport master (
        input  s0_arvalid, s0_araddr, s0_rready,
        input  s1_arvalid, s1_araddr, s1_rready,
        output s0_arready, s0_rdata, s0_rvalid, s0_rlast,
        output s1_arready, s1_rdata, s1_rvalid, s1_rlast,
        output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        output m_axi_rready,
        input  m_axi_arready, m_axi_rdata, m_axi_rvalid, m_axi_rlast
    );

    modport slave (
        output s0_arvalid, s0_araddr, s0_rready,
        output s1_arvalid, s1_araddr, s1_rready,
        input  s0_arready, s0_rdata, s0_rvalid, s0_rlast,
        input  s1_arready, s1_rdata, s1_rvalid, s1_rlast,
        input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        input  m_axi_rready,
        output m_axi_arready, m_axi_rdata, m_axi_rvalid, m_axi_rlast
    );
endinterface

// File: rtl/axi_line_read_arbiter.sv
// Round-robin arbiter sharing one AXI read channel between two cache-line requesters,
// one line-aligned INCR burst outstanding at a time.
module axi_line_read_arbiter #(
    parameter int BYTES_PER_LINE = 64,
    parameter int BEAT_BYTES     = 8,
    parameter int BEATS          = BYTES_PER_LINE / BEAT_BYTES,
    parameter int OFFSET_SIZE    = $clog2(BYTES_PER_LINE)
) (
    input  logic                    clk,
    input  logic                    reset,
    axi_line_read_arbiter_if.master bus,
    output logic                    err_rlast,
    output logic [1:0]              dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    // One extra count value so an overlong burst saturates instead of wrapping to a legal index.
    localparam int               CNT_W     = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(BEATS);
    localparam logic [63:0]      LINE_MASK = ~((64'd1 << OFFSET_SIZE) - 64'd1);

    state_t           state;
    state_t           state_nxt;
    logic             grant;
    logic             last_grant;
    logic [63:0]      addr_q;
    logic [CNT_W-1:0] beat_cnt;

    logic winner;
    logic ar_hs;
    logic sel_rready;
    logic r_hs;
    logic in_data;

    assign dbg_state = state;

    always_comb begin
        winner = bus.s1_arvalid;
        if (bus.s0_arvalid && bus.s1_arvalid) begin
            winner = ~last_grant;
        end
        // Gated by reset so no request is acknowledged while the block is held in reset.
        ar_hs      = (state == IDLE) && reset && (bus.s0_arvalid || bus.s1_arvalid);
        in_data    = (state == DATA);
        sel_rready = grant ? bus.s1_rready : bus.s0_rready;
        r_hs       = in_data && bus.m_axi_rvalid && sel_rready;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ar_hs) state_nxt = ADDR;
            ADDR:    if (bus.m_axi_arready) state_nxt = DATA;
            DATA:    if (r_hs && bus.m_axi_rlast) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.s0_arready    = ar_hs && !winner;
        bus.s1_arready    = ar_hs && winner;

        bus.m_axi_arvalid = (state == ADDR);
        bus.m_axi_araddr  = addr_q;
        bus.m_axi_arlen   = 8'(BEATS - 1);
        bus.m_axi_arsize  = 3'd3;
        bus.m_axi_arburst = 2'b01;
        bus.m_axi_rready  = in_data && sel_rready;

        // The requester not holding the grant sees a quiet R channel.
        bus.s0_rvalid     = in_data && !grant && bus.m_axi_rvalid;
        bus.s0_rlast      = in_data && !grant && bus.m_axi_rlast;
        bus.s0_rdata      = (in_data && !grant) ? bus.m_axi_rdata : 64'd0;
        bus.s1_rvalid     = in_data && grant && bus.m_axi_rvalid;
        bus.s1_rlast      = in_data && grant && bus.m_axi_rlast;
        bus.s1_rdata      = (in_data && grant) ? bus.m_axi_rdata : 64'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            addr_q     <= 64'd0;
            beat_cnt   <= '0;
            err_rlast  <= 1'b0;
        end else begin
            if (ar_hs) begin
                grant      <= winner;
                last_grant <= winner;
                addr_q     <= (winner ? bus.s1_araddr : bus.s0_araddr) & LINE_MASK;
            end

            if (state == ADDR && bus.m_axi_arready) begin
                beat_cnt <= '0;
            end else if (r_hs && beat_cnt != CNT_MAX) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end

            // Flags both an early rlast and a missing rlast on the final expected beat.
            if (r_hs && (bus.m_axi_rlast != (beat_cnt == LAST_BEAT))) begin
                err_rlast <= 1'b1;
            end
        end
    end
endmodule
